// File: rtl/costas_loop_filter_pkg.sv
// Shared definitions for the Costas loop feedback path: saturation helpers
// and the lock FSM state encoding.
package costas_loop_filter_pkg;

    typedef enum logic {
        ACQ  = 1'b0,
        LOCK = 1'b1
    } lock_state_e;

    // Signed range limits for a w-bit two's complement value (w <= 63).
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

endpackage

// File: rtl/costas_phase_detector.sv
// BPSK phase detector: err = sign(I) * Q, registered, with the single
// unrepresentable negation (-MIN) clamped to MAX.
module costas_phase_detector
    import costas_loop_filter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] i_i,
    input  logic signed [WIDTH-1:0] q_i,
    input  logic                    vld_i,
    output logic signed [WIDTH-1:0] err_o,
    output logic                    vld_o
);

    logic signed [WIDTH-1:0] err_d, err_q;
    logic                    vld_q;

    always_comb begin
        err_d = q_i;
        if (i_i < 0) err_d = WIDTH'(sat(-64'(q_i), WIDTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
            vld_q <= 1'b0;
        end else if (enable) begin
            vld_q <= vld_i;
            if (vld_i) err_q <= err_d;
        end
    end

    assign err_o = err_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/costas_loop_filter.sv
// Costas loop feedback producer: phase detector, integrate-and-dump,
// PI loop filter and dump-rate lock detector.
module costas_loop_filter
    import costas_loop_filter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int DUMP_LEN    = 8,
    parameter int LOCK_THRESH = 512,
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_CNT  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [3:0]              KP_SHIFT,
    input  logic [3:0]              KI_SHIFT,
    input  logic signed [WIDTH-1:0] i_tdata,
    input  logic signed [WIDTH-1:0] q_tdata,
    input  logic                    iq_tvalid,
    output logic signed [WIDTH-1:0] feedback_tdata,
    output logic                    feedback_tvalid,
    output logic                    locked
);

    localparam int LOG2_DL = $clog2(DUMP_LEN);
    localparam int SUM_W   = WIDTH + LOG2_DL;
    localparam int RUN_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [LOG2_DL-1:0] CNT_LAST   = LOG2_DL'(DUMP_LEN - 1);
    localparam logic [RUN_W-1:0]   RUN_LOCK   = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0]   RUN_UNLOCK = RUN_W'(UNLOCK_CNT);
    localparam logic [RUN_W-1:0]   RUN_SAT    = RUN_W'(RUN_MAX);
    localparam logic [WIDTH-1:0]   THR        = WIDTH'(LOCK_THRESH);

    // S1
    logic signed [WIDTH-1:0] err;
    logic                    err_vld;

    costas_phase_detector #(.WIDTH(WIDTH)) u_pd (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .i_i    (i_tdata),
        .q_i    (q_tdata),
        .vld_i  (iq_tvalid),
        .err_o  (err),
        .vld_o  (err_vld)
    );

    // S2: integrate-and-dump
    logic [LOG2_DL-1:0]      cnt_q, cnt_d;
    logic signed [SUM_W-1:0] sum_q, sum_d, sum_nxt;
    logic signed [WIDTH-1:0] e_q, e_d, e2_q;
    logic                    dmp_q, dmp_d, dmp2_q;

    always_comb begin
        sum_nxt = sum_q + {{LOG2_DL{err[WIDTH-1]}}, err};
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        e_d     = e_q;
        dmp_d   = 1'b0;
        if (err_vld) begin
            if (cnt_q == CNT_LAST) begin
                // Mean of WIDTH-bit samples always fits back into WIDTH bits.
                e_d   = WIDTH'(sum_nxt >>> LOG2_DL);
                sum_d = '0;
                cnt_d = '0;
                dmp_d = 1'b1;
            end else begin
                sum_d = sum_nxt;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // S3: PI filter
    logic signed [ACC_WIDTH-1:0] e_ext, ki_term, integ_q, integ_d, integ_nxt;
    logic signed [WIDTH-1:0]     kp_term, fb_q, fb_d, fb_nxt;
    logic                        tv_q, tv_d;

    always_comb begin
        e_ext     = {{(ACC_WIDTH - WIDTH){e2_q[WIDTH-1]}}, e2_q};
        ki_term   = e_ext >>> KI_SHIFT;
        kp_term   = e2_q >>> KP_SHIFT;
        integ_nxt = ACC_WIDTH'(sat(64'(integ_q) + 64'(ki_term), ACC_WIDTH));
        fb_nxt    = WIDTH'(sat(64'(kp_term) + 64'(integ_nxt), WIDTH));
        integ_d   = integ_q;
        fb_d      = fb_q;
        tv_d      = 1'b0;
        if (dmp2_q) begin
            integ_d = integ_nxt;
            fb_d    = fb_nxt;
            tv_d    = 1'b1;
        end
    end

    // Lock FSM, stepped on the same dump as the PI update
    lock_state_e      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [WIDTH-1:0] abs_e;
    logic             in_th;

    always_comb begin
        abs_e   = WIDTH'(sat((e2_q < 0) ? -64'(e2_q) : 64'(e2_q), WIDTH));
        in_th   = (abs_e <= THR);
        run_inc = (run_q == RUN_SAT) ? run_q : run_q + 1'b1;
        state_d = state_q;
        run_d   = run_q;
        if (dmp2_q) begin
            case (state_q)
                ACQ: begin
                    if (!in_th)                     run_d = '0;
                    else if (run_inc == RUN_LOCK) begin
                        state_d = LOCK;
                        run_d   = '0;
                    end else                        run_d = run_inc;
                end
                LOCK: begin
                    if (in_th)                        run_d = '0;
                    else if (run_inc == RUN_UNLOCK) begin
                        state_d = ACQ;
                        run_d   = '0;
                    end else                          run_d = run_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            sum_q   <= '0;
            e_q     <= '0;
            dmp_q   <= 1'b0;
            e2_q    <= '0;
            dmp2_q  <= 1'b0;
            integ_q <= '0;
            fb_q    <= '0;
            tv_q    <= 1'b0;
            state_q <= ACQ;
            run_q   <= '0;
        end else if (enable) begin
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            e_q     <= e_d;
            dmp_q   <= dmp_d;
            // Retiming stage between the dump shifter and the PI adders.
            e2_q    <= e_q;
            dmp2_q  <= dmp_q;
            integ_q <= integ_d;
            fb_q    <= fb_d;
            tv_q    <= tv_d;
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    assign feedback_tdata  = fb_q;
    assign feedback_tvalid = tv_q & enable;
    assign locked          = (state_q == LOCK);

endmodule
